// File: rtl/student_coeff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : student_coeff_pkg
//  Purpose  : Shared types for the double-buffered coefficient bank:
//             burst FSM state encoding and the bank-select type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package student_coeff_pkg;

    // Burst sequencer states. FLUSH is the single cycle in which the last
    // read data is still on its way out of the RAM output register.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } coeff_state_e;

    // Identifies one of the two physical banks.
    typedef logic bank_sel_t;

    localparam int unsigned NUM_BANKS = 2;

endpackage
`default_nettype wire

// File: rtl/student_coeff_ram.sv
`default_nettype none
// ============================================================================
//  Module   : student_coeff_ram
//  Purpose  : Simple dual-port block RAM, one write port and one read port
//             with a registered read. Contents are never reset; the array is
//             filled through the write port.
//  Ports    : clk_i              - clock
//             wr_en_i/addr/data  - write port
//             rd_en_i/rd_addr_i  - read request, data on rd_data_o next cycle
//             rd_data_o          - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module student_coeff_ram #(
    parameter int    AddrWidth     = 10,
    parameter int    CoeffDataSize = 16,
    parameter string INIT_F        = ""
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [AddrWidth-1:0]     wr_addr_i,
    input  logic [CoeffDataSize-1:0] wr_data_i,
    input  logic                     rd_en_i,
    input  logic [AddrWidth-1:0]     rd_addr_i,
    output logic [CoeffDataSize-1:0] rd_data_o
);

    localparam int Depth = 1 << AddrWidth;

    logic [CoeffDataSize-1:0] r_mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= r_mem[rd_addr_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/student_coeff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : student_coeff_bank
//  Purpose  : Double-buffered coefficient store. Host writes land in the
//             shadow bank; a swap request exchanges shadow and active banks
//             once no burst is running. A burst streams active-bank
//             coefficients 0..N-1 with a fixed two-cycle latency.
//  Ports    : clk_i, rst_ni           - clock, synchronous active-low reset
//             wr_valid_i/addr/data    - shadow write request
//             wr_ready_o              - write accepted (low while swap pending)
//             swap_req_i, swap_ack_o  - swap request / one-cycle acknowledge
//             start_i, num_taps_i     - burst start / length (0 = full depth)
//             coeff_o, coeff_valid_o,
//             coeff_last_o            - burst output stream
//             busy_o, active_bank_o   - status
//             checksum_o              - only with STUDENT_COEFF_CHECKSUM_EN:
//                                       wrapping sum of accepted shadow data
//  Config   : `define STUDENT_COEFF_CHECKSUM_EN to add checksum_o
//  Revision : 1.0 - initial release
// ============================================================================
module student_coeff_bank
    import student_coeff_pkg::*;
#(
    parameter int    AddrWidth     = 10,
    parameter int    CoeffDataSize = 16,
    parameter string INIT_F        = ""
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_valid_i,
    input  logic [AddrWidth-1:0]     wr_addr_i,
    input  logic [CoeffDataSize-1:0] wr_data_i,
    output logic                     wr_ready_o,
    input  logic                     swap_req_i,
    output logic                     swap_ack_o,
    input  logic                     start_i,
    input  logic [AddrWidth:0]       num_taps_i,
    output logic [CoeffDataSize-1:0] coeff_o,
    output logic                     coeff_valid_o,
    output logic                     coeff_last_o,
    output logic                     busy_o,
    output logic                     active_bank_o
`ifdef STUDENT_COEFF_CHECKSUM_EN
    ,
    output logic [CoeffDataSize+AddrWidth-1:0] checksum_o
`endif
);

    coeff_state_e             r_state;
    logic [AddrWidth-1:0]     r_addr;
    logic [AddrWidth-1:0]     r_last_addr;
    logic                     r_valid;
    logic                     r_last;
    bank_sel_t                r_rd_bank;
    bank_sel_t                r_active;
    logic                     r_pending;
    logic                     r_ack;

    logic                     w_wr_fire;
    logic                     w_swap_go;
    logic                     w_rd_en;
    bank_sel_t                w_shadow;
    logic [CoeffDataSize-1:0] w_rd_data [NUM_BANKS];

    assign w_shadow  = ~r_active;
    assign w_wr_fire = wr_valid_i && !r_pending;
    assign w_rd_en   = (r_state == ST_BURST);
    // A start in the same idle cycle takes priority; the swap waits.
    assign w_swap_go = (r_state == ST_IDLE) && !start_i && r_pending;

    // ------------------------------------------------------------------
    // Two identical banks; only the shadow one sees write enables.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            student_coeff_ram #(
                .AddrWidth     (AddrWidth),
                .CoeffDataSize (CoeffDataSize),
                .INIT_F        (INIT_F)
            ) u_ram (
                .clk_i     (clk_i),
                .wr_en_i   (w_wr_fire && (w_shadow == bank_sel_t'(gi))),
                .wr_addr_i (wr_addr_i),
                .wr_data_i (wr_data_i),
                .rd_en_i   (w_rd_en),
                .rd_addr_i (r_addr),
                .rd_data_o (w_rd_data[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Burst sequencer and swap handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_active    <= 1'b0;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_ack     <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            // Requests arriving while one is pending simply merge into it.
            r_pending <= r_pending | swap_req_i;

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        // Length 0 and 2**AddrWidth both truncate to the
                        // all-ones final address.
                        r_last_addr <= AddrWidth'(num_taps_i - (AddrWidth+1)'(1));
                        r_addr      <= '0;
                        r_rd_bank   <= r_active;
                        r_state     <= ST_BURST;
                    end else if (w_swap_go) begin
                        r_active  <= ~r_active;
                        r_ack     <= 1'b1;
                        r_pending <= 1'b0;
                    end
                end
                ST_BURST: begin
                    // Data for this address appears next cycle, so the
                    // valid/last flags are delayed by the same register stage.
                    r_valid <= 1'b1;
                    r_last  <= (r_addr == r_last_addr);
                    if (r_addr == r_last_addr) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_addr <= r_addr + AddrWidth'(1);
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready_o    = !r_pending;
    assign swap_ack_o    = r_ack;
    assign coeff_valid_o = r_valid;
    assign coeff_last_o  = r_last;
    // RAM output is not reset, so gate it to keep coeff_o clean outside bursts.
    assign coeff_o       = r_valid ? w_rd_data[r_rd_bank] : '0;
    assign busy_o        = (r_state != ST_IDLE);
    assign active_bank_o = r_active;

`ifdef STUDENT_COEFF_CHECKSUM_EN
    localparam int CsWidth = CoeffDataSize + AddrWidth;

    logic [CsWidth-1:0] r_checksum;

    // Writes are blocked while a swap is pending, so clear and accumulate
    // never coincide.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_checksum <= '0;
        end else if (w_swap_go) begin
            r_checksum <= '0;
        end else if (w_wr_fire) begin
            r_checksum <= r_checksum + CsWidth'(wr_data_i);
        end
    end

    assign checksum_o = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_student_coeff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_student_coeff_bank
//  Purpose  : Self-checking bench for student_coeff_bank (AddrWidth=3).
//             A reference model holds both banks as plain arrays; bursts push
//             expected (data, last, cycle) records into a queue that an
//             independent monitor pops whenever coeff_valid_o is high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_student_coeff_bank;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + DW;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready_o;
    logic          swap_req;
    logic          swap_ack_o;
    logic          start;
    logic [AW:0]   num_taps;
    logic [DW-1:0] coeff_o;
    logic          coeff_valid_o;
    logic          coeff_last_o;
    logic          busy_o;
    logic          active_bank_o;
`ifdef STUDENT_COEFF_CHECKSUM_EN
    logic [CW-1:0] checksum_o;
`endif

    student_coeff_bank #(
        .AddrWidth     (AW),
        .CoeffDataSize (DW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .wr_valid_i    (wr_valid),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready_o),
        .swap_req_i    (swap_req),
        .swap_ack_o    (swap_ack_o),
        .start_i       (start),
        .num_taps_i    (num_taps),
        .coeff_o       (coeff_o),
        .coeff_valid_o (coeff_valid_o),
        .coeff_last_o  (coeff_last_o),
        .busy_o        (busy_o),
        .active_bank_o (active_bank_o)
`ifdef STUDENT_COEFF_CHECKSUM_EN
        ,
        .checksum_o    (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int ack_count = 0;
    int valid_count = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- reference model ----------------
    logic [DW-1:0] mbank [2][DEPTH];
    bit            mact;
    logic [CW-1:0] csum;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (swap_ack_o === 1'b1) ack_count++;
            if (coeff_valid_o === 1'b1) begin
                valid_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", coeff_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("coeff", coeff_o, e.d);
                    check("last", coeff_last_o, e.last);
                    check("latency", cyc, e.cyc);
                end
            end else begin
                check("last_without_valid", coeff_last_o, 0);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        check("wr_ready", wr_ready_o, 1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        mbank[mact ? 0 : 1][a] = d;
        csum = csum + CW'(d);
    endtask

    task automatic wr_done();
        @(negedge clk);
        wr_valid = 1'b0;
`ifdef STUDENT_COEFF_CHECKSUM_EN
        check("checksum", checksum_o, csum);
`endif
    endtask

    task automatic write_rand(input int cnt);
        for (int i = 0; i < cnt; i++) wr(AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
        wr_done();
    endtask

    task automatic do_swap();
        int acks0;
        acks0 = ack_count;
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        check("wr_ready_pending", wr_ready_o, 0);
        check("ack_not_yet", swap_ack_o, 0);
        @(negedge clk);
        check("swap_ack", swap_ack_o, 1);
        mact = ~mact;
        csum = '0;
        check("active_bank", active_bank_o, mact);
        check("wr_ready_after_swap", wr_ready_o, 1);
`ifdef STUDENT_COEFF_CHECKSUM_EN
        check("checksum_clear", checksum_o, 0);
`endif
        @(negedge clk);
        check("one_ack", ack_count - acks0, 1);
    endtask

    // n_in: value for num_taps_i; pre_swap: swap request the cycle before
    // start; swap_at / restart_at: burst-relative cycle (0 = none).
    task automatic burst(input int n_in, input bit pre_swap, input int swap_at, input int restart_at);
        int n, t, acks0, vals0;
        bit swapping;
        exp_t e;
        n = (n_in == 0) ? DEPTH : n_in;
        swapping = pre_swap || (swap_at > 0);
        if (pre_swap) begin
            @(negedge clk);
            swap_req = 1'b1;
        end
        @(negedge clk);
        swap_req = 1'b0;
        start    = 1'b1;
        num_taps = (AW+1)'(n_in);
        t        = cyc;
        acks0    = ack_count;
        vals0    = valid_count;
        for (int i = 0; i < n; i++) begin
            e.d = mbank[int'(mact)][i];
            e.last = (i == n - 1);
            e.cyc = t + 2 + i;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            start    = (k == restart_at);
            num_taps = (AW+1)'($urandom_range(0, DEPTH));
            swap_req = (k == swap_at);
            check("busy", busy_o, (k <= n + 1) ? 1 : 0);
            check("no_early_ack", swap_ack_o, 0);
        end
        swap_req = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        if (swapping) begin
            check("deferred_ack", swap_ack_o, 1);
            mact = ~mact;
            csum = '0;
        end else begin
            check("no_ack", swap_ack_o, 0);
        end
        check("active_after_burst", active_bank_o, mact);
        @(negedge clk);
        check("ack_count", ack_count - acks0, swapping ? 1 : 0);
        check("valid_count", valid_count - vals0, n);
    endtask

    task automatic reset_mid_burst();
        exp_t e;
        int t;
        @(negedge clk);
        start    = 1'b1;
        num_taps = 4;
        t        = cyc;
        e.d = mbank[int'(mact)][0];
        e.last = 1'b0;
        e.cyc = t + 2;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        mact = 1'b0;
        csum = '0;
        check("rst_valid", coeff_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_active", active_bank_o, 0);
        check("rst_coeff", coeff_o, 0);
        check("rst_wr_ready", wr_ready_o, 1);
        @(negedge clk);
        check("rst_still_no_valid", coeff_valid_o, 0);
        check("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; start = 1'b0; num_taps = '0;
        mact = 1'b0; csum = '0;
        for (int b = 0; b < 2; b++) for (int a = 0; a < DEPTH; a++) mbank[b][a] = '0;

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        check("reset_valid", coeff_valid_o, 0);
        check("reset_last", coeff_last_o, 0);
        check("reset_coeff", coeff_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_ack", swap_ack_o, 0);
        check("reset_active", active_bank_o, 0);
        check("reset_wr_ready", wr_ready_o, 1);
`ifdef STUDENT_COEFF_CHECKSUM_EN
        check("reset_checksum", checksum_o, 0);
`endif
        mon_en = 1'b1;

        // Fill shadow bank: addr 0..3 = 1..4, rest random; swap; 4-tap burst.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), (a < 4) ? DW'(a + 1) : DW'($urandom));
        wr_done();
        do_swap();
        burst(4, 0, 0, 0);

        // Fill the other bank, swap back, full-depth burst via num_taps=0.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), DW'($urandom));
        wr_done();
        do_swap();
        burst(0, 0, 0, 0);

`ifdef STUDENT_COEFF_CHECKSUM_EN
        wr(0, 16'hFFFF);
        wr(1, 16'hFFFF);
        wr_done();
        check("checksum_ffff_x2", checksum_o, 32'h1FFFE);
        do_swap();
`endif

        burst(4, 0, 2, 0);      // swap requested mid-burst
        burst(4, 0, 0, 2);      // second start mid-burst is ignored
        burst(3, 1, 2, 0);      // start beats pending swap; repeat request absorbed
        burst(DEPTH, 0, DEPTH + 1, 1);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: write_rand($urandom_range(1, 4));
                1: do_swap();
                default: begin
                    int n, nn, sa, ra;
                    n  = $urandom_range(0, DEPTH);
                    nn = (n == 0) ? DEPTH : n;
                    sa = $urandom_range(0, 1) ? $urandom_range(1, nn + 1) : 0;
                    ra = $urandom_range(0, 1) ? $urandom_range(1, nn + 1) : 0;
                    burst(n, 1'($urandom_range(0, 1)), sa, ra);
                end
            endcase
        end

        reset_mid_burst();
        burst(0, 0, 0, 0);      // bank contents survive reset

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
